// File: rtl/sop_pkg.sv
// Shared widths, tag type and saturation limits for the sum-of-products accumulator.
package sop_pkg;
   localparam int SOP_IN_W  = 37;
   localparam int SOP_ACC_W = 48;
   localparam int SOP_LAT   = 2;

   localparam logic [SOP_ACC_W-1:0] ACC_MAX = {1'b0, {(SOP_ACC_W-1){1'b1}}};
   localparam logic [SOP_ACC_W-1:0] ACC_MIN = {1'b1, {(SOP_ACC_W-1){1'b0}}};

   typedef struct packed {
      logic valid;
      logic last;
   } sop_tag_t;
endpackage

// File: rtl/sop_tag_pipe.sv
// Enable-gated LAT-deep shift register of beat tags.
// Its tail lines up with the DSP result for the same beat.
module sop_tag_pipe
   import sop_pkg::*;
#(
   parameter int LAT = SOP_LAT
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     i_en,
   input  sop_tag_t i_tag,
   output sop_tag_t o_tag
);

   sop_tag_t r_stage [LAT];

   // NOTE: the stage array is reset on purpose, because a stale valid bit would retire a phantom beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
      end else if (i_en) begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_tag = r_stage[LAT-1];

endmodule

// File: rtl/sop_accum.sv
// Saturating group accumulator behind the sum-of-products DSP.
// It owns the DSP clock-enable, so output backpressure freezes the whole pipeline.
module sop_accum
   import sop_pkg::*;
#(
   parameter int IN_W  = SOP_IN_W,
   parameter int ACC_W = SOP_ACC_W,
   parameter int LAT   = SOP_LAT,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [2:0]        dsp_ena,
   input  logic [IN_W-1:0]   resulta,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             r_out_valid;
   logic [ACC_W-1:0] r_out_sum;
   logic [CNT_W-1:0] r_out_count;
   logic             r_out_ovf;

   logic             w_stall;
   sop_tag_t         w_tag_in;
   sop_tag_t         w_tag_al;
   logic [ACC_W:0]   w_sum_ext;
   logic             w_ovf_now;
   logic [ACC_W-1:0] w_sum_sat;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_stall  = r_out_valid & ~out_ready;
   assign dsp_ena  = {3{~w_stall}};
   assign in_ready = ~w_stall & ~reset;

   // NOTE: every signal gets a value on every path here, so no latch is inferred.
   always_comb begin
      w_tag_in.valid = in_valid & in_ready;
      w_tag_in.last  = in_last & in_valid;
      w_sum_ext = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-IN_W){resulta[IN_W-1]}}, resulta};
      // Sign of the wide sum differs from the narrow MSB exactly on signed overflow.
      w_ovf_now = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];
      w_sum_sat = w_sum_ext[ACC_W-1:0];
      if (w_ovf_now) w_sum_sat = w_sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
      w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
   end

   sop_tag_pipe #(.LAT(LAT)) u_tag_pipe (
      .clk   (clk),
      .reset (reset),
      .i_en  (~w_stall),
      .i_tag (w_tag_in),
      .o_tag (w_tag_al)
   );

   // NOTE: sequential state uses <= so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else if (!w_stall) begin
         // Not stalled with a valid output means it is being consumed this cycle.
         if (r_out_valid) r_out_valid <= 1'b0;
         if (w_tag_al.valid) begin
            if (w_tag_al.last) begin
               r_out_sum   <= w_sum_sat;
               r_out_count <= w_cnt_inc;
               r_out_ovf   <= r_ovf | w_ovf_now;
               r_out_valid <= 1'b1;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_ovf       <= 1'b0;
            end else begin
               r_acc <= w_sum_sat;
               r_cnt <= w_cnt_inc;
               r_ovf <= r_ovf | w_ovf_now;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_count = r_out_count;
   assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sop_accum.sv
// Bench for sop_accum: DSP latency model, group-level reference model,
// per-cycle compare process and directed literal checks.
module tb_sop_accum;
   localparam int IN_W  = 37;
   localparam int ACC_W = 48;
   localparam int LAT   = 2;
   localparam int CNT_W = 16;
   localparam longint SAT_HI = 64'sd140737488355327;
   localparam longint SAT_LO = -64'sd140737488355328;
   localparam longint P36M1  = 64'sd68719476735;
   localparam longint N36    = -64'sd68719476736;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b1;
   logic in_ready, out_valid, out_ovf;
   logic [2:0] dsp_ena;
   logic [IN_W-1:0] resulta;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   longint in_data = 0;

   sop_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .dsp_ena(dsp_ena), .resulta(resulta),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   // DSP model: the operand value reappears on resulta after LAT enabled edges.
   logic [IN_W-1:0] dsp_pipe [LAT];
   always @(posedge clk) begin
      if (dsp_ena == 3'b111) begin
         dsp_pipe[0] <= in_data[IN_W-1:0];
         for (int i = 1; i < LAT; i++) dsp_pipe[i] <= dsp_pipe[i-1];
      end
   end
   assign resulta = dsp_pipe[LAT-1];

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      longint sum;
      longint cnt;
      longint ovf;
   } res_t;

   res_t   exp_q[$];
   res_t   log_q[$];
   longint m_acc = 0;
   longint m_cnt = 0;
   longint m_ovf = 0;
   int     stall_cycles = 0;
   int     ena_low_cycles = 0;

   // Compare process: everything is stable at the falling edge.
   bit     prev_hold = 1'b0;
   longint prev_sum, prev_cnt, prev_ovf;
   always @(negedge clk) begin : cmp
      bit   stall;
      res_t e, g;
      stall = out_valid && !out_ready;
      check("in_ready", longint'(in_ready), longint'(!stall && !reset));
      check("dsp_ena", longint'(dsp_ena), stall ? 0 : 7);
      if (stall) stall_cycles++;
      if (dsp_ena == 3'b000) ena_low_cycles++;
      if (prev_hold) begin
         check("hold_sum", longint'(out_sum), prev_sum);
         check("hold_count", longint'(out_count), prev_cnt);
         check("hold_ovf", longint'(out_ovf), prev_ovf);
      end
      if (reset) begin
         exp_q.delete();
         m_acc = 0; m_cnt = 0; m_ovf = 0;
      end else begin
         if (out_valid && out_ready) begin
            g.sum = longint'($signed(out_sum));
            g.cnt = longint'(out_count);
            g.ovf = longint'(out_ovf);
            log_q.push_back(g);
            if (exp_q.size() == 0) begin
               check("spurious_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("model_sum", g.sum, e.sum);
               check("model_count", g.cnt, e.cnt);
               check("model_ovf", g.ovf, e.ovf);
            end
         end
         if (in_valid && in_ready) begin
            m_acc = m_acc + in_data;
            if (m_acc > SAT_HI) begin m_acc = SAT_HI; m_ovf = 1; end
            if (m_acc < SAT_LO) begin m_acc = SAT_LO; m_ovf = 1; end
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (in_last) begin
               e.sum = m_acc; e.cnt = m_cnt; e.ovf = m_ovf;
               exp_q.push_back(e);
               m_acc = 0; m_cnt = 0; m_ovf = 0;
            end
         end
      end
      prev_hold = stall && !reset;
      prev_sum  = longint'(out_sum);
      prev_cnt  = longint'(out_count);
      prev_ovf  = longint'(out_ovf);
   end

   function automatic longint rand37();
      logic [IN_W-1:0] r;
      r = IN_W'({$urandom(), $urandom()});
      return longint'($signed(r));
   endfunction

   // One cycle: drive at posedge+1, report acceptance, return at next posedge+1.
   task automatic beat(input bit v, input bit l, input longint d, output bit acc);
      in_valid = v; in_last = l; in_data = d;
      #1;
      acc = v && in_ready;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bit a;
      repeat (n) beat(1'b0, 1'($urandom_range(0, 1)), rand37(), a);
   endtask

   task automatic send(input bit l, input longint d);
      bit a;
      int tries;
      tries = 0;
      do begin
         beat(1'b1, l, d, a);
         tries++;
      end while (!a && tries < 100);
      if (!a) check("accept_timeout", 0, 1);
   endtask

   task automatic check_log(input string name, input int idx, input longint s, input longint c, input longint o);
      if (log_q.size() <= idx) begin
         check({name, "_present"}, log_q.size(), idx + 1);
      end else begin
         check({name, "_sum"}, log_q[idx].sum, s);
         check({name, "_count"}, log_q[idx].cnt, c);
         check({name, "_ovf"}, log_q[idx].ovf, o);
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   longint grp_a [3] = '{1, 2, 3};
   longint grp_b [5] = '{1000, -250, 33, 7, -1};

   initial begin : stim
      int n0, k, ia, ib;
      bit a;

      // Reset values
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_sum", longint'(out_sum), 0);
      check("rst_out_count", longint'(out_count), 0);
      check("rst_out_ovf", longint'(out_ovf), 0);
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_dsp_ena", longint'(dsp_ena), 7);
      reset = 1'b0;
      idle(2);

      // Group 10,-3,7,100 with latency LAT+1 after the last beat
      n0 = log_q.size();
      send(0, 10); send(0, -3); send(0, 7);
      beat(1'b1, 1'b1, 100, a);
      check("lat_t1", longint'(out_valid), 0);
      idle(1);
      check("lat_t2", longint'(out_valid), 0);
      idle(1);
      check("lat_t3_valid", longint'(out_valid), 1);
      check("lat_t3_sum", longint'($signed(out_sum)), 114);
      check("lat_t3_count", longint'(out_count), 4);
      idle(1);
      check("lat_pulse_end", longint'(out_valid), 0);
      idle(2);
      check_log("grp4", n0, 114, 4, 0);

      // Back-to-back {5} and {1,2}
      n0 = log_q.size();
      send(1, 5); send(0, 1); send(1, 2);
      idle(6);
      check_log("b2b_first", n0, 5, 1, 0);
      check_log("b2b_second", n0 + 1, 3, 2, 0);

      // Consecutive single-term groups: no bubble between results
      send(1, 5); send(1, 6);
      idle(1);
      check("nobub_v0", longint'(out_valid), 1);
      check("nobub_s0", longint'($signed(out_sum)), 5);
      idle(1);
      check("nobub_v1", longint'(out_valid), 1);
      check("nobub_s1", longint'($signed(out_sum)), 6);
      idle(1);
      check("nobub_end", longint'(out_valid), 0);
      idle(3);

      // Backpressure for 5 cycles with a second group streaming
      n0 = log_q.size();
      stall_cycles = 0; ena_low_cycles = 0;
      k = 0; ia = 0; ib = 0;
      while (ib < 5 && k < 60) begin
         out_ready = (k >= 10);
         if (ia < 3) begin
            beat(1'b1, ia == 2, grp_a[ia], a);
            if (a) ia++;
         end else begin
            beat(1'b1, ib == 4, grp_b[ib], a);
            if (a) ib++;
         end
         k++;
      end
      out_ready = 1'b1;
      idle(8);
      check("stall_in_ready_low", stall_cycles, 5);
      check("stall_dsp_ena_low", ena_low_cycles, 5);
      check_log("stall_a", n0, 6, 3, 0);
      check_log("stall_b", n0 + 1, 789, 5, 0);

      // Positive saturation, then a clean group
      n0 = log_q.size();
      for (int i = 0; i < 2100; i++) send(i == 2099, P36M1);
      idle(5);
      check_log("sat_pos", n0, SAT_HI, 2100, 1);
      send(1, 4);
      idle(5);
      check_log("after_sat", n0 + 1, 4, 1, 0);

      // Exactly reaching the minimum does not overflow; one more beat does
      n0 = log_q.size();
      for (int i = 0; i < 2048; i++) send(i == 2047, N36);
      for (int i = 0; i < 2049; i++) send(i == 2048, N36);
      idle(5);
      check_log("min_exact", n0, SAT_LO, 2048, 0);
      check_log("sat_neg", n0 + 1, SAT_LO, 2049, 1);

      // Reset mid-group discards everything
      n0 = log_q.size();
      send(0, 1); send(0, 2);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(8);
      check("rst_mid_no_output", log_q.size(), n0);
      send(1, 9);
      idle(5);
      check_log("after_rst", n0, 9, 1, 0);

      // Single beat at the most negative input
      n0 = log_q.size();
      send(1, N36);
      idle(5);
      check_log("single_neg", n0, -64'sd68719476736, 1, 0);

      // Randomized traffic with backpressure and occasional reset
      for (int i = 0; i < 800; i++) begin
         int r;
         longint d;
         out_ready = ($urandom_range(0, 9) < 7);
         reset = ($urandom_range(0, 249) == 0);
         r = $urandom_range(0, 9);
         d = (r == 0) ? P36M1 : (r == 1) ? N36 : rand37();
         beat($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, d, a);
      end
      reset = 1'b0;
      out_ready = 1'b1;
      idle(12);
      check("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
